// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle processor: opcodes, funct codes,
// FSM state encoding and instruction field positions.
package mcycle_pkg;

  localparam int INSTR_W  = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 13;
  localparam int RS_MSB    = 12;
  localparam int RS_LSB    = 10;
  localparam int RT_MSB    = 9;
  localparam int RT_LSB    = 7;
  localparam int RD_MSB    = 6;
  localparam int RD_LSB    = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 6;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = 7;
  localparam int TGT_MSB   = 12;
  localparam int TGT_LSB   = 0;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;
  localparam logic [2:0] OP_JAL   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_SLT = 4'd4;
  localparam logic [3:0] FN_JR  = 4'd8;

  localparam logic [REG_AW-1:0] LINK_REG = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/mc_regfile.sv
// Eight-entry register file, two combinational read ports and one write port.
// R0 always reads zero and ignores writes.
module mc_regfile
  import mcycle_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/mcycle_proc.sv
// Multi-cycle 16-bit-instruction processor: FETCH/DECODE/EXEC/MEM/WB/HALT FSM
// with registered memory handshakes and a one-cycle retire pulse.
module mcycle_proc
  import mcycle_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 13
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               retire,
  output logic               halted,
  output logic [PC_W-1:0]    pc
);

  state_t               state;
  logic [INSTR_W-1:0]   ir;
  logic [DATA_W-1:0]    a_reg;
  logic [DATA_W-1:0]    b_reg;
  logic [DATA_W-1:0]    res_reg;
  logic                 wb_en;
  logic [REG_AW-1:0]    wb_addr;

  logic [2:0]           op;
  logic [REG_AW-1:0]    rs;
  logic [REG_AW-1:0]    rt;
  logic [REG_AW-1:0]    rd;
  logic [3:0]           funct;
  logic signed [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]      target_pc;

  logic [DATA_W-1:0]    rf_a;
  logic [DATA_W-1:0]    rf_b;
  logic                 rf_we;
  logic [REG_AW-1:0]    rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;

  assign op        = ir[OP_MSB:OP_LSB];
  assign rs        = ir[RS_MSB:RS_LSB];
  assign rt        = ir[RT_MSB:RT_LSB];
  assign rd        = ir[RD_MSB:RD_LSB];
  assign funct     = ir[FUNCT_MSB:FUNCT_LSB];
  assign imm_ext   = {{(DATA_W-IMM_W){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
  assign target_pc = PC_W'(ir[TGT_MSB:TGT_LSB]);
  assign imem_addr = pc;

  function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] fn,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] xs;
    logic signed [DATA_W-1:0] ys;
    xs = $signed(x);
    ys = $signed(y);
    case (fn)
      FN_ADD:  return x + y;
      FN_SUB:  return x - y;
      FN_AND:  return x & y;
      FN_OR:   return x | y;
      FN_SLT:  return (xs < ys) ? DATA_W'(1) : '0;
      default: return '0;
    endcase
  endfunction

  // Unknown funct codes retire as a NOP, so only real ALU ops write back.
  function automatic logic alu_writes(input logic [3:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  // jal links in EXEC; everything else writes back in WB through the same port.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state == ST_EXEC && op == OP_JAL) begin
      rf_we    = 1'b1;
      rf_waddr = LINK_REG;
      rf_wdata = DATA_W'(pc);
    end else if (state == ST_WB) begin
      rf_we    = wb_en;
      rf_waddr = wb_addr;
      rf_wdata = res_reg;
    end
  end

  mc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs),
    .ra_data (rf_a),
    .rb_addr (rt),
    .rb_data (rf_b),
    .we      (rf_we),
    .wa      (rf_waddr),
    .wd      (rf_wdata)
  );

  always_ff @(posedge clk) begin
    retire <= 1'b0;
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      retire   <= 1'b0;
      halted   <= 1'b0;
      wb_en    <= 1'b0;
    end else begin
      case (state)
        // FETCH: the idle cycle after reset raises the request; later entries arrive with it set
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            pc       <= pc + PC_W'(1);
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        // DECODE: operand latch
        ST_DECODE: begin
          a_reg <= rf_a;
          b_reg <= rf_b;
          state <= ST_EXEC;
        end
        // EXEC
        ST_EXEC: begin
          case (op)
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                pc       <= a_reg[PC_W-1:0];
                retire   <= 1'b1;
                imem_req <= 1'b1;
                state    <= ST_FETCH;
              end else begin
                res_reg <= alu_op(funct, a_reg, b_reg);
                wb_en   <= alu_writes(funct);
                wb_addr <= rd;
                state   <= ST_WB;
              end
            end
            OP_ADDI: begin
              res_reg <= a_reg + imm_ext;
              wb_en   <= 1'b1;
              wb_addr <= rt;
              state   <= ST_WB;
            end
            OP_LW, OP_SW: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_SW);
              dmem_addr  <= a_reg + imm_ext;
              dmem_wdata <= b_reg;
              wb_en      <= (op == OP_LW);
              wb_addr    <= rt;
              state      <= ST_MEM;
            end
            OP_BEQ: begin
              if (a_reg == b_reg) pc <= pc + imm_ext[PC_W-1:0];
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
            OP_J, OP_JAL: begin
              pc       <= target_pc;
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
            default: begin
              halted <= 1'b1;
              retire <= 1'b1;
              state  <= ST_HALT;
            end
          endcase
        end
        // MEM: request and operands stay frozen until ack
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end else begin
              res_reg <= dmem_rdata;
              state   <= ST_WB;
            end
          end
        end
        // WB
        ST_WB: begin
          retire   <= 1'b1;
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_proc.sv
// Directed bench for mcycle_proc: instruction ROM and stallable data memory
// models, one task per scenario with hand-computed expectations.
module tb_mcycle_proc;

  localparam logic [2:0] T_RTYPE = 3'b000;
  localparam logic [2:0] T_ADDI  = 3'b001;
  localparam logic [2:0] T_LW    = 3'b010;
  localparam logic [2:0] T_SW    = 3'b011;
  localparam logic [2:0] T_BEQ   = 3'b100;
  localparam logic [2:0] T_J     = 3'b101;
  localparam logic [2:0] T_JAL   = 3'b110;
  localparam logic [15:0] T_HALT_W = 16'hE000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        retire;
  logic        halted;
  logic [12:0] pc;

  logic [15:0] rom [0:8191];
  logic [15:0] dmem [0:63];
  logic        imem_force_ack = 1'b0;
  int          dmem_wait = 0;
  int          dcnt = 0;
  logic        overlap = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcycle_proc #(.DATA_W(16), .PC_W(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .halted     (halted),
    .pc         (pc)
  );

  assign imem_ack   = imem_force_ack | imem_req;
  assign imem_rdata = imem_force_ack ? 16'h2085 : rom[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt == dmem_wait);
  assign dmem_rdata = dmem[dmem_addr[5:0]];

  always @(posedge clk) begin
    if (!dmem_req || dmem_ack) dcnt <= 0;
    else dcnt <= dcnt + 1;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[5:0]] <= dmem_wdata;
  end

  always @(negedge clk) if (imem_req && dmem_req) overlap <= 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input int imm);
    logic [6:0] im;
    im = imm[6:0];
    return {op, rs, rt, im};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [3:0] fn);
    return {T_RTYPE, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] enc_j(input logic [2:0] op, input int tgt);
    logic [12:0] t;
    t = tgt[12:0];
    return {op, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8192; i++) rom[i] = T_HALT_W;
  endtask

  task automatic wait_retires(input int n, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (retire) seen++;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_dreq(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (dmem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int nz;
    clear_rom();
    rst = 1'b1;
    tick();
    tick();
    nz = 0;
    for (int i = 0; i < 8; i++) if (dut.u_regfile.regs[i] !== 16'h0) nz++;
    checks++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req: imem_req=%b dmem_req=%b required 0 0", imem_req, dmem_req);
    end
    checks++;
    if (retire !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: retire=%b halted=%b required 0 0", retire, halted);
    end
    checks++;
    if (pc !== 13'h0 || nz != 0) begin
      failures++;
      $display("FAIL reset_state: pc=%0h nonzero_regs=%0d required 0 0", pc, nz);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 13'h0) begin
      failures++;
      $display("FAIL reset_first_fetch: imem_req=%b addr=%0h required 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu_latency();
    logic [15:0] seen_ret;
    logic [15:0] exp_ret;
    clear_rom();
    rom[0] = enc_i(T_ADDI, 3'd0, 3'd1, 5);
    rom[1] = enc_i(T_ADDI, 3'd0, 3'd2, -3);
    rom[2] = enc_r(3'd1, 3'd2, 3'd3, 4'd0);
    exp_ret = 16'h1110;
    seen_ret = '0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      tick();
      seen_ret[c] = retire;
    end
    checks++;
    if (seen_ret !== exp_ret) begin
      failures++;
      $display("FAIL alu_retire_cycles: got=%016b required=%016b", seen_ret, exp_ret);
    end
    checks++;
    if (dut.u_regfile.regs[1] !== 16'd5 || dut.u_regfile.regs[2] !== 16'hFFFD) begin
      failures++;
      $display("FAIL addi_values: R1=%0h R2=%0h required 5 fffd",
               dut.u_regfile.regs[1], dut.u_regfile.regs[2]);
    end
    checks++;
    if (dut.u_regfile.regs[3] !== 16'd2) begin
      failures++;
      $display("FAIL add_wrap: R3=%0h required 2", dut.u_regfile.regs[3]);
    end
  endtask

  task automatic test_alu_ops();
    bit ok;
    clear_rom();
    rom[0] = enc_i(T_ADDI, 3'd0, 3'd1, 5);
    rom[1] = enc_i(T_ADDI, 3'd0, 3'd2, -3);
    rom[2] = enc_r(3'd1, 3'd2, 3'd4, 4'd1);
    rom[3] = enc_r(3'd1, 3'd2, 3'd5, 4'd3);
    rom[4] = enc_r(3'd1, 3'd2, 3'd6, 4'd2);
    rom[5] = enc_r(3'd2, 3'd1, 3'd7, 4'd4);
    rom[6] = enc_r(3'd1, 3'd2, 3'd3, 4'd4);
    rom[7] = enc_r(3'd1, 3'd2, 3'd1, 4'd5);
    rom[8] = enc_i(T_ADDI, 3'd0, 3'd0, 7);
    do_reset();
    wait_halt(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL alu_ops_halt: halted=%b required 1", halted);
    end
    checks++;
    if (dut.u_regfile.regs[4] !== 16'd8 || dut.u_regfile.regs[5] !== 16'hFFFD) begin
      failures++;
      $display("FAIL sub_or: R4=%0h R5=%0h required 8 fffd",
               dut.u_regfile.regs[4], dut.u_regfile.regs[5]);
    end
    checks++;
    if (dut.u_regfile.regs[6] !== 16'd5) begin
      failures++;
      $display("FAIL and: R6=%0h required 5", dut.u_regfile.regs[6]);
    end
    checks++;
    if (dut.u_regfile.regs[7] !== 16'd1 || dut.u_regfile.regs[3] !== 16'd0) begin
      failures++;
      $display("FAIL slt_signed: R7=%0h R3=%0h required 1 0",
               dut.u_regfile.regs[7], dut.u_regfile.regs[3]);
    end
    checks++;
    if (dut.u_regfile.regs[1] !== 16'd5 || dut.u_regfile.regs[0] !== 16'd0) begin
      failures++;
      $display("FAIL nop_r0: R1=%0h R0=%0h required 5 0",
               dut.u_regfile.regs[1], dut.u_regfile.regs[0]);
    end
  endtask

  task automatic test_mem_stall();
    bit ok;
    int n;
    bit stable;
    logic [15:0] a0;
    logic [15:0] w0;
    logic we0;
    clear_rom();
    rom[0] = enc_i(T_ADDI, 3'd0, 3'd1, 5);
    rom[1] = enc_i(T_SW, 3'd0, 3'd1, 2);
    rom[2] = enc_i(T_LW, 3'd0, 3'd4, 2);
    dmem_wait = 3;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      wait_dreq(40, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL mem_req_%0d: dmem_req=0 required 1", k);
      end else begin
        n = 1;
        stable = 1'b1;
        a0 = dmem_addr;
        w0 = dmem_wdata;
        we0 = dmem_we;
        while (n < 20) begin
          tick();
          if (!dmem_req) break;
          n++;
          if (dmem_addr !== a0 || dmem_we !== we0 || (we0 && dmem_wdata !== w0)) stable = 1'b0;
        end
        checks++;
        if (a0 !== 16'd2 || we0 !== (k == 0)) begin
          failures++;
          $display("FAIL mem_addr_we_%0d: addr=%0h we=%b required 2 %b", k, a0, we0, k == 0);
        end
        checks++;
        if (n != 4 || !stable) begin
          failures++;
          $display("FAIL mem_hold_%0d: cycles=%0d stable=%b required 4 1", k, n, stable);
        end
        if (k == 0) begin
          checks++;
          if (w0 !== 16'd5) begin
            failures++;
            $display("FAIL sw_wdata: wdata=%0h required 5", w0);
          end
        end
      end
    end
    wait_halt(40, ok);
    checks++;
    if (!ok || dut.u_regfile.regs[4] !== 16'd5 || dmem[2] !== 16'd5) begin
      failures++;
      $display("FAIL lw_result: halted=%b R4=%0h mem2=%0h required 1 5 5",
               halted, dut.u_regfile.regs[4], dmem[2]);
    end
    dmem_wait = 0;
  endtask

  task automatic test_branch();
    bit ok;
    logic [12:0] exp_pc;
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      rom[0] = enc_i(T_ADDI, 3'd0, 3'd1, 5);
      rom[1] = enc_i(T_ADDI, 3'd0, 3'd2, -3);
      rom[2] = enc_j(T_J, 10);
      rom[10] = (k == 0) ? enc_i(T_BEQ, 3'd1, 3'd1, -2) : enc_i(T_BEQ, 3'd1, 3'd2, -2);
      exp_pc = (k == 0) ? 13'd9 : 13'd11;
      do_reset();
      wait_retires(3, 40, ok);
      checks++;
      if (!ok || pc !== 13'd10) begin
        failures++;
        $display("FAIL jump_%0d: pc=%0h required a", k, pc);
      end
      wait_retires(1, 20, ok);
      checks++;
      if (!ok || pc !== exp_pc) begin
        failures++;
        $display("FAIL beq_%0d: pc=%0h required %0h", k, pc, exp_pc);
      end
    end
  endtask

  task automatic test_jal_jr();
    bit ok;
    clear_rom();
    rom[0] = enc_j(T_J, 32'h20);
    rom[32'h20] = enc_j(T_JAL, 32'h100);
    rom[32'h100] = enc_r(3'd7, 3'd0, 3'd0, 4'd8);
    do_reset();
    wait_retires(2, 40, ok);
    checks++;
    if (!ok || pc !== 13'h100 || dut.u_regfile.regs[7] !== 16'h21) begin
      failures++;
      $display("FAIL jal: pc=%0h R7=%0h required 100 21", pc, dut.u_regfile.regs[7]);
    end
    wait_retires(1, 20, ok);
    checks++;
    if (!ok || pc !== 13'h21) begin
      failures++;
      $display("FAIL jr: pc=%0h required 21", pc);
    end
    wait_halt(20, ok);
    checks++;
    if (!ok || pc !== 13'h22) begin
      failures++;
      $display("FAIL jal_halt: halted=%b pc=%0h required 1 22", halted, pc);
    end
  endtask

  task automatic test_halt();
    bit ok;
    int rets;
    int reqs;
    clear_rom();
    do_reset();
    rets = 0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (retire) rets++;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || rets != 1 || pc !== 13'd1) begin
      failures++;
      $display("FAIL halt_entry: halted=%b retires=%0d pc=%0h required 1 1 1", halted, rets, pc);
    end
    reqs = 0;
    rets = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (imem_req || dmem_req) reqs++;
      if (retire) rets++;
      if (!halted) reqs++;
    end
    checks++;
    if (reqs != 0 || rets != 0) begin
      failures++;
      $display("FAIL halt_quiet: req_or_unhalt_cycles=%0d retires=%0d required 0 0", reqs, rets);
    end
    rom[0] = enc_i(T_ADDI, 3'd0, 3'd3, 9);
    do_reset();
    checks++;
    if (pc !== 13'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset: pc=%0h halted=%b required 0 0", pc, halted);
    end
    wait_retires(1, 20, ok);
    checks++;
    if (!ok || dut.u_regfile.regs[3] !== 16'd9) begin
      failures++;
      $display("FAIL halt_resume: R3=%0h required 9", dut.u_regfile.regs[3]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_rom();
    rom[0] = enc_i(T_ADDI, 3'd0, 3'd1, 5);
    rom[1] = enc_i(T_LW, 3'd0, 3'd4, 2);
    dmem_wait = 5;
    do_reset();
    wait_dreq(30, ok);
    tick();
    tick();
    checks++;
    if (!ok || dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_stall: dmem_req=%b required 1", dmem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (dmem_req !== 1'b0 || pc !== 13'd0 || retire !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: dmem_req=%b pc=%0h retire=%b required 0 0 0", dmem_req, pc, retire);
    end
    checks++;
    if (dut.u_regfile.regs[4] !== 16'd0 || dut.u_regfile.regs[1] !== 16'd0) begin
      failures++;
      $display("FAIL mid_regs: R4=%0h R1=%0h required 0 0",
               dut.u_regfile.regs[4], dut.u_regfile.regs[1]);
    end
    imem_force_ack = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    imem_force_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || pc !== 13'd0) begin
      failures++;
      $display("FAIL late_ack: imem_req=%b pc=%0h required 1 0", imem_req, pc);
    end
    wait_retires(1, 20, ok);
    checks++;
    if (!ok || dut.u_regfile.regs[1] !== 16'd5) begin
      failures++;
      $display("FAIL mid_resume: R1=%0h required 5", dut.u_regfile.regs[1]);
    end
    dmem_wait = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen_ret;
    logic [15:0] exp_ret;
    clear_rom();
    rom[0] = enc_i(T_ADDI, 3'd0, 3'd1, 7);
    rom[1] = enc_i(T_SW, 3'd0, 3'd1, 3);
    rom[2] = enc_i(T_LW, 3'd0, 3'd5, 3);
    exp_ret = 16'h2110;
    seen_ret = '0;
    dmem_wait = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      tick();
      seen_ret[c] = retire;
    end
    checks++;
    if (seen_ret !== exp_ret) begin
      failures++;
      $display("FAIL mem_latency: got=%016b required=%016b", seen_ret, exp_ret);
    end
    checks++;
    if (dut.u_regfile.regs[5] !== 16'd7) begin
      failures++;
      $display("FAIL b2b_lw: R5=%0h required 7", dut.u_regfile.regs[5]);
    end
    checks++;
    if (overlap !== 1'b0) begin
      failures++;
      $display("FAIL req_overlap: seen=%b required 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_alu_latency();
    test_alu_ops();
    test_mem_stall();
    test_branch();
    test_jal_jr();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcycle_proc.md
MCYCLE_PROC -- requirements
Module: mcycle_proc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath and register width (DATA_W >= 16).
REQ-002 SHALL have parameter PC_W, default 13, instruction address width (PC_W <= DATA_W).
REQ-003 SHALL have these ports:
  clk  in  1  sole clock; all state updates on its rising edge.
  rst  in  1  synchronous, active-high reset.
  imem_req  out  1  instruction fetch request.
  imem_addr  out  PC_W  fetch address (= pc).
  imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
  imem_rdata  in  16  instruction word.
  dmem_req  out  1  data access request.
  dmem_we  out  1  1 = store, 0 = load.
  dmem_addr  out  DATA_W  data address.
  dmem_wdata  out  DATA_W  store data.
  dmem_ack  in  1  data access complete; dmem_rdata valid this cycle for loads.
  dmem_rdata  in  DATA_W  load data.
  retire  out  1  one-cycle pulse when an instruction completes.
  halted  out  1  high while in HALT.
  pc  out  PC_W  current program counter.
REQ-004 One clock; reset is synchronous and active-high; clock and reset ports are named clk and rst.

Function
REQ-005 SHALL decode the 16-bit instruction as: op[15:13], rs[12:10], rt[9:7], rd[6:4], funct[3:0], imm7[6:0] (sign-extended to DATA_W), target[12:0] (zero-extended/truncated to PC_W).
REQ-006 SHALL implement these opcodes: 000 R-type; 001 addi; 010 lw; 011 sw; 100 beq; 101 j; 110 jal; 111 halt.
REQ-007 R-type funct: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 1/0), 8 jr; any other funct SHALL retire as a NOP with no register write.
REQ-008 SHALL hold 8 DATA_W registers; R0 reads as zero and writes to R0 are discarded.
REQ-009 Arithmetic SHALL be modulo 2^DATA_W with no overflow flag; the PC SHALL increment modulo 2^PC_W (all-ones wraps to 0).
REQ-010 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 FETCH: imem_req=1, imem_addr=pc; hold until imem_ack is sampled high (ack in the first request cycle is legal); on ack, latch IR, pc<=pc+1, go to DECODE.
REQ-012 DECODE: latch A=R[rs], B=R[rt]; go to EXEC.
REQ-013 EXEC: R-type ALU/addi -> WB; lw/sw -> MEM with address A+imm7; beq -> if A==B then pc<=pc+imm7; retire; go to FETCH; j -> pc<=target, retire, go to FETCH; jal -> R7<=pc (already incremented), pc<=target, retire, go to FETCH; jr -> pc<=A[PC_W-1:0], retire, go to FETCH; halt -> go to HALT.
REQ-014 MEM: dmem_req=1 and dmem_addr/dmem_we/dmem_wdata (=B) held stable until dmem_ack; on ack: a load latches dmem_rdata and goes to WB; a store retires and goes to FETCH.
REQ-015 WB: write R[rd] (R-type) or R[rt] (addi, lw); retire; go to FETCH.
REQ-016 HALT: halted=1, retire pulses once on entry, no memory requests; HALT is left only by rst.
REQ-017 imem_req and dmem_req SHALL never both be high; neither request SHALL drop before its ack.
REQ-018 Latency with zero-wait memory: ALU/addi 4 cycles; beq/j/jal/jr 3 cycles; sw 4 cycles; lw 5 cycles; each wait cycle adds 1.

Reset
REQ-019 On rst: state=FETCH, pc=0, all registers=0, imem_req=0, dmem_req=0, retire=0, halted=0; the first fetch request is issued in the cycle after rst deasserts.
REQ-020 rst asserted mid-request SHALL drop the request in the next cycle, with no register write and no retire; a late ack SHALL be ignored.

Structure
REQ-021 A shared package mcycle_pkg SHALL hold the opcode and funct constants, the FSM state encoding and the instruction field bit positions.
REQ-022 The register file SHALL be a sub-module mc_regfile (parameter DATA_W, 2 read ports, 1 write port, R0 hardwired).

Verification
REQ-023 addi R1,R0,5; addi R2,R0,-3; add R3,R1,R2 with zero-wait memory -> R3=2, retire pulses at cycles 4, 8 and 12 after reset release.
REQ-024 sw R1,2(R0) then lw R4,2(R0) with dmem_ack delayed 3 cycles -> dmem_addr=2, dmem_wdata=5, R4=5, request held stable for 4 cycles.
REQ-025 beq R1,R1,-2 at pc=10 -> pc becomes 9; beq R1,R2 (not equal) -> pc becomes 11.
REQ-026 jal 0x100 at pc=0x20 -> R7=0x21, pc=0x100; then jr R7 -> pc=0x21.
REQ-027 halt -> halted=1, no further imem_req for 20 cycles; rst -> pc=0 and fetching resumes.
REQ-028 rst pulsed during a 5-cycle stalled dmem_req -> request low the next cycle, no register write, pc=0.
